inverse_matrix_ctrl: RTL

Sequencer for the Gauss-Jordan matrix-inversion datapath. It accepts a start request and issues one row command at a time (probe, swap, normalize, eliminate) to the inversion datapath over a valid/ready command channel. It waits for the datapath's completion response after each command, searches for a nonzero pivot, and reports done/singular status to the host.

---
 rtl/inverse_matrix_ctrl_if.sv | 35 +++
 rtl/inverse_matrix_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/inverse_matrix_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : inverse_matrix_ctrl_if
//  Brief   : Host start/status plus datapath command/response channel for
//            the Gauss-Jordan inversion sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
interface inverse_matrix_ctrl_if #(
    parameter int IDX_W = 3
) ();
    logic             start;
    logic             busy;
    logic             done;
    logic             singular;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [IDX_W-1:0] cmd_row;
    logic [IDX_W-1:0] cmd_pivot;
    logic             rsp_valid;
    logic             rsp_zero;

    // Sequencer side
    modport master (
        input  start, cmd_ready, rsp_valid, rsp_zero,
        output busy, done, singular, cmd_valid, cmd_op, cmd_row, cmd_pivot
    );

    // Host / datapath side
    modport slave (
        output start, cmd_ready, rsp_valid, rsp_zero,
        input  busy, done, singular, cmd_valid, cmd_op, cmd_row, cmd_pivot
    );
endinterface
`default_nettype wire

// File: rtl/inverse_matrix_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : inverse_matrix_ctrl
//  Brief   : Gauss-Jordan inversion sequencer. Issues PROBE/SWAP/NORM/ELIM
//            row commands one at a time and reports done/singular.
//  Options : INV_CTRL_PIVOT_EN - enables partial-pivot search (row counter,
//            SWAP command). Undefined: only row k is probed.
//  Rev     : 1.0  initial release
// ============================================================================
module inverse_matrix_ctrl #(
    parameter int N     = 3,
    parameter int IDX_W = 3
) (
    input  wire                   clk,
    input  wire                   rst_n,
    inverse_matrix_ctrl_if.master bus
);

    localparam logic [1:0] OP_PROBE = 2'b00;
`ifdef INV_CTRL_PIVOT_EN
    localparam logic [1:0] OP_SWAP  = 2'b01;
`endif
    localparam logic [1:0] OP_NORM  = 2'b10;
    localparam logic [1:0] OP_ELIM  = 2'b11;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PROBE = 3'd1,
`ifdef INV_CTRL_PIVOT_EN
        S_SWAP  = 3'd2,
`endif
        S_NORM  = 3'd3,
        S_ELIM  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t           state;
    logic             waiting;     // 0: ISSUE phase, 1: WAIT phase
    logic [IDX_W-1:0] pivot_k;
`ifdef INV_CTRL_PIVOT_EN
    logic [IDX_W-1:0] row_cnt;
`endif

    logic [IDX_W-1:0] elim_first;
    logic [IDX_W-1:0] elim_step;
    logic [IDX_W-1:0] elim_cand;

    // Next elimination row: first row after NORM, else the row after the
    // current one, always skipping the pivot row. A value of N means done.
    always_comb begin
        elim_first = (pivot_k == '0) ? IDX_W'(1) : '0;
        elim_step  = bus.cmd_row + 1'b1;
        if (elim_step == pivot_k) begin
            elim_step = elim_step + 1'b1;
        end
        elim_cand  = (state == S_NORM) ? elim_first : elim_step;
    end

    // Sequencer state machine with registered command and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            waiting       <= 1'b0;
            pivot_k       <= '0;
`ifdef INV_CTRL_PIVOT_EN
            row_cnt       <= '0;
`endif
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.singular  <= 1'b0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_op    <= OP_PROBE;
            bus.cmd_row   <= '0;
            bus.cmd_pivot <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                // FIN is the done cycle; it accepts a new start just like IDLE
                S_IDLE, S_FIN: begin
                    state <= S_IDLE;
                    if (bus.start) begin
                        pivot_k       <= '0;
`ifdef INV_CTRL_PIVOT_EN
                        row_cnt       <= '0;
`endif
                        bus.singular  <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= S_PROBE;
                        waiting       <= 1'b0;
                        bus.cmd_valid <= 1'b1;
                        bus.cmd_op    <= OP_PROBE;
                        bus.cmd_row   <= '0;
                        bus.cmd_pivot <= '0;
                    end
                end
                default: begin
                    if (!waiting) begin
                        if (bus.cmd_ready) begin
                            bus.cmd_valid <= 1'b0;
                            waiting       <= 1'b1;
                        end
                    end else if (bus.rsp_valid) begin
                        // Default: the response launches another command
                        waiting       <= 1'b0;
                        bus.cmd_valid <= 1'b1;
                        case (state)
                            S_PROBE: begin
`ifdef INV_CTRL_PIVOT_EN
                                if (bus.rsp_zero) begin
                                    if (row_cnt == LAST_IDX) begin
                                        bus.singular  <= 1'b1;
                                        bus.cmd_valid <= 1'b0;
                                        bus.done      <= 1'b1;
                                        bus.busy      <= 1'b0;
                                        state         <= S_FIN;
                                    end else begin
                                        row_cnt     <= row_cnt + 1'b1;
                                        bus.cmd_row <= row_cnt + 1'b1;
                                    end
                                end else if (row_cnt == pivot_k) begin
                                    state         <= S_NORM;
                                    bus.cmd_op    <= OP_NORM;
                                    bus.cmd_row   <= pivot_k;
                                    bus.cmd_pivot <= pivot_k;
                                end else begin
                                    // cmd_row/cmd_pivot already hold (r, k)
                                    state      <= S_SWAP;
                                    bus.cmd_op <= OP_SWAP;
                                end
`else
                                if (bus.rsp_zero) begin
                                    bus.singular  <= 1'b1;
                                    bus.cmd_valid <= 1'b0;
                                    bus.done      <= 1'b1;
                                    bus.busy      <= 1'b0;
                                    state         <= S_FIN;
                                end else begin
                                    state         <= S_NORM;
                                    bus.cmd_op    <= OP_NORM;
                                    bus.cmd_row   <= pivot_k;
                                    bus.cmd_pivot <= pivot_k;
                                end
`endif
                            end
`ifdef INV_CTRL_PIVOT_EN
                            S_SWAP: begin
                                state         <= S_NORM;
                                bus.cmd_op    <= OP_NORM;
                                bus.cmd_row   <= pivot_k;
                                bus.cmd_pivot <= pivot_k;
                            end
`endif
                            S_NORM, S_ELIM: begin
                                if (elim_cand < N_IDX) begin
                                    state       <= S_ELIM;
                                    bus.cmd_op  <= OP_ELIM;
                                    bus.cmd_row <= elim_cand;
                                end else if (pivot_k == LAST_IDX) begin
                                    bus.cmd_valid <= 1'b0;
                                    bus.done      <= 1'b1;
                                    bus.busy      <= 1'b0;
                                    state         <= S_FIN;
                                end else begin
                                    pivot_k       <= pivot_k + 1'b1;
`ifdef INV_CTRL_PIVOT_EN
                                    row_cnt       <= pivot_k + 1'b1;
`endif
                                    state         <= S_PROBE;
                                    bus.cmd_op    <= OP_PROBE;
                                    bus.cmd_row   <= pivot_k + 1'b1;
                                    bus.cmd_pivot <= pivot_k + 1'b1;
                                end
                            end
                            default: begin
                                bus.cmd_valid <= 1'b0;
                                state         <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
